odpc_window_minmax: RTL

ODPC_WINDOW_MINMAX -- requirements
Module: odpc_window_minmax

---
 rtl/odpc_pkg.sv | 13 +
 rtl/odpc_minmax_tree.sv | 34 +++
 rtl/odpc_window_minmax.sv | 118 +++++++++++
 3 files changed

// File: rtl/odpc_pkg.sv
// Shared definitions for the ODPC sliding-window min/max block:
// parameter defaults and the FILL/RUN state encoding.
package odpc_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DEPTH = 4;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_RUN  = 1'b1
   } odpc_state_t;

endpackage : odpc_pkg

// File: rtl/odpc_minmax_tree.sv
// Purely combinational balanced reduction: unsigned max and min over DEPTH
// window entries, built as a heap-indexed binary tree of pairwise compares.
module odpc_minmax_tree
   import odpc_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic [0:WIDTH-1] i_data [DEPTH],
   output logic [0:WIDTH-1] o_max,
   output logic [0:WIDTH-1] o_min
);

   // Node k combines children 2k and 2k+1; leaves live at DEPTH..2*DEPTH-1,
   // so the root (node 1) sits log2(DEPTH) compare levels above the inputs.
   logic [0:WIDTH-1] w_max [1:2*DEPTH-1];
   logic [0:WIDTH-1] w_min [1:2*DEPTH-1];

   for (genvar g_leaf = 0; g_leaf < DEPTH; g_leaf++) begin : g_leaves
      assign w_max[DEPTH+g_leaf] = i_data[g_leaf];
      assign w_min[DEPTH+g_leaf] = i_data[g_leaf];
   end

   for (genvar g_node = 1; g_node < DEPTH; g_node++) begin : g_nodes
      assign w_max[g_node] = (w_max[2*g_node] >= w_max[2*g_node+1]) ?
                             w_max[2*g_node] : w_max[2*g_node+1];
      assign w_min[g_node] = (w_min[2*g_node] <= w_min[2*g_node+1]) ?
                             w_min[2*g_node] : w_min[2*g_node+1];
   end

   assign o_max = w_max[1];
   assign o_min = w_min[1];

endmodule : odpc_minmax_tree

// File: rtl/odpc_window_minmax.sv
// Sliding-window reference min/max: each sample accepted once the window is
// full is paired with the max/min of the DEPTH samples that preceded it.
module odpc_window_minmax
   import odpc_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             s_valid,
   input  logic [0:WIDTH-1] s_data,
   output logic             s_ready,
   output logic [0:WIDTH-1] max,
   output logic [0:WIDTH-1] min,
   output logic [0:WIDTH-1] in_x,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             window_full
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   odpc_state_t      r_state;
   odpc_state_t      w_state_nxt;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_fill_cnt;
   logic [0:WIDTH-1] r_buf [DEPTH];
   logic [0:WIDTH-1] r_max;
   logic [0:WIDTH-1] r_min;
   logic [0:WIDTH-1] r_in_x;
   logic             r_m_valid;

   logic             w_accept;
   logic             w_fill_done;
   logic [0:WIDTH-1] w_win_max;
   logic [0:WIDTH-1] w_win_min;

   // A single output register: upstream may push whenever that register is
   // empty or being drained this cycle. Flush drops any offered sample.
   assign s_ready     = !r_m_valid || m_ready;
   assign w_accept    = s_valid && s_ready && !flush;
   assign w_fill_done = w_accept && (r_fill_cnt == CNT_W'(DEPTH - 1));

   odpc_minmax_tree #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_tree (
      .i_data (r_buf),
      .o_max  (w_win_max),
      .o_min  (w_win_min)
   );

   // NOTE: defaults first so every path assigns w_state_nxt; no latch.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_FILL: if (w_fill_done) w_state_nxt = ST_RUN;
         ST_RUN:  w_state_nxt = ST_RUN;
         default: w_state_nxt = ST_FILL;
      endcase
      if (flush) w_state_nxt = ST_FILL;
   end

   // NOTE: non-blocking assignments keep all registers sampling pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_FILL;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_wr_ptr   <= '0;
         r_fill_cnt <= '0;
      end else if (w_accept) begin
         r_wr_ptr <= r_wr_ptr + 1'b1;
         if (r_state == ST_FILL) r_fill_cnt <= r_fill_cnt + 1'b1;
      end
   end

   // NOTE: the window storage is small and must read as zero after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
      end else if (w_accept) begin
         r_buf[r_wr_ptr] <= s_data;
      end
   end

   // In RUN the write slot is the oldest entry, so the tree still sees the
   // previous DEPTH samples while the new one is captured alongside them.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_max     <= '0;
         r_min     <= '0;
         r_in_x    <= '0;
         r_m_valid <= 1'b0;
      end else if (flush) begin
         r_m_valid <= 1'b0;
      end else if (w_accept && r_state == ST_RUN) begin
         r_max     <= w_win_max;
         r_min     <= w_win_min;
         r_in_x    <= s_data;
         r_m_valid <= 1'b1;
      end else if (m_ready) begin
         r_m_valid <= 1'b0;
      end
   end

   assign max         = r_max;
   assign min         = r_min;
   assign in_x        = r_in_x;
   assign m_valid     = r_m_valid;
   assign window_full = (r_state == ST_RUN);

endmodule : odpc_window_minmax
